io_arbiter: RTL
===============

# io_arbiter

Two-requester, round-robin arbiter and sequencer for the 16-port, 8-bit `IO` block. Each requester places one read or one write transaction using a req/ack handshake. The arbiter converts the transaction into the `IO` control strobes: `io_enable`, `sel_io`, `sel_p` and `out_data`. For reads it captures `in_data` after a programmable latency and returns it with the ack. It sits between the CPU datapath (requester 0) and a secondary master such as a port poller (requester 1), on one side, and the `IO` block, on the other.

## Interface
- `RD_LAT`, default 1: number of cycles from the `IO` sampling edge until `in_data` is captured. Legal range 1..15.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low (`reset`=0 resets).
- `req0`, `req1`  in  1 each: request level, held until the matching ack.
- `rw0`, `rw1`  in  1 each: 0 = read, 1 = write (same coding as `sel_io`).
- `port0`, `port1`  in  4 each: target port number.
- `wdata0`, `wdata1`  in  8 each: write data.
- `ack0`, `ack1`  out  1 each: one-cycle completion pulse.
- `rdata`  out  8: read result, valid while an ack is high.
- `busy`  out  1: high in every state except IDLE.
- `grant`  out  2: one-hot owner of the current transaction; 0 in IDLE.
- `io_enable`  out  1: strobe to the `IO` block.
- `sel_io`  out  1: direction to the `IO` block.
- `sel_p`  out  4: port select to the `IO` block.
- `out_data`  out  8: write data to the `IO` block.
- `in_data`  in  8: read data from the `IO` block.

## Operation
- State machine: IDLE → ISSUE → (read: WAIT) → DONE → IDLE.
- **IDLE**
  - With no request, stay in IDLE.
  - With exactly one `reqN`=1, grant that requester.
  - With both requests high, grant the requester that did not win last. `last` resets to 1, so requester 0 wins the first tie.
  - On grant, latch `rw`, `port` and `wdata` into internal registers, update `last`, set `grant`, and go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - `io_enable`=1; `sel_io`, `sel_p` and `out_data` are driven from the latched registers.
  - Write: go to DONE.
  - Read: clear the counter and go to WAIT.
- **WAIT** (exactly `RD_LAT` cycles)
  - `io_enable`=0; the counter increments.
  - On the edge that ends the last WAIT cycle, load `rdata` from `in_data`, then go to DONE.
- **DONE** (1 cycle)
  - `ackN`=1 for the granted requester only, then go to IDLE.
  - `rdata` keeps its last captured value; a write does not change it.
- Outside ISSUE: `io_enable`=0, and `sel_io`, `sel_p` and `out_data` hold their latched values.
- Requests are sampled only in IDLE. A request that rises during another transaction waits in order.
- If `req` drops before its ack, the transaction still completes and the ack still pulses.
- Requester inputs changing after the grant have no effect.
- Reset mid-transaction aborts immediately. No ack is issued and `io_enable` drops asynchronously.

## Timing
- Reset values: state IDLE, `last`=1, counter 0, `grant`=0, `ack0`=`ack1`=0, `busy`=0, `io_enable`=0, `sel_io`=0, `sel_p`=0, `out_data`=0, `rdata`=0.
- All outputs are registered or decoded from state only. There are no combinational paths from `req` or `in_data` to outputs.
- The `IO` block acts on the edge that ends the ISSUE cycle.
- Write latency: request seen in IDLE at cycle 0, ISSUE at cycle 1, ack at cycle 2. Minimum spacing is 3 cycles per write.
- Read latency: ack at cycle 2+`RD_LAT`. Minimum spacing is 3+`RD_LAT` cycles.
- With both requesters held high continuously, grants strictly alternate 0, 1, 0, 1, …
- The counter is 4 bits wide. `RD_LAT` outside 1..15 is a configuration error, flagged by a simulation-time `$display`.

## Structure
- Shared defines file `io_defs`: data width 8, port width 4, the state encodings (IDLE, ISSUE, WAIT, DONE), and the `sel_io` codes READ=0 and WRITE=1.
- One natural sub-module: `rr_arb2`. It is a 2-way round-robin with a `last` flip-flop, inputs `req[1:0]` and `en`, output one-hot `gnt`, and the same async active-low reset.
- The counter and the request latches live in `io_arbiter`.

## Test plan
- Reset: hold `reset`=0 while `req0`=1 → all outputs 0, no `io_enable`. Release → `grant`=01 on the next edge.
- Single write: `req0`, `rw0`=1, `port0`=5, `wdata0`=8'hA5 → `io_enable`=1, `sel_io`=1, `sel_p`=5, `out_data`=A5 in cycle 1; `ack0` in cycle 2; `rdata` unchanged.
- Single read with `RD_LAT`=2: `req1`, `rw1`=0, `port1`=3, `in_data`=8'h3C → `io_enable` in cycle 1, `ack1` in cycle 4 with `rdata`=3C.
- Contention: `req0` and `req1` both held high for 4 transactions → grant order 0, 1, 0, 1; acks never overlap.
- Abort: assert reset during WAIT of a read → `io_enable` and `busy` go to 0 immediately; no `ack1`; the first grant after release goes to requester 0 on a tie.
- Early drop: `req0` drops in ISSUE → the write completes and `ack0` still pulses in cycle 2.

Source files
------------

// File: rtl/io_arbiter_pkg.sv
// Shared IO defines: bus widths, sequencer state encoding and sel_io direction codes.
package io_arbiter_pkg;

  localparam int DATA_W = 8;
  localparam int PORT_W = 4;
  localparam int CNT_W  = 4;

  // sel_io coding, shared with the requesters' rw inputs
  localparam logic IO_READ  = 1'b0;
  localparam logic IO_WRITE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } io_state_t;

endpackage

// File: rtl/io_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, grants the requester that did not win last.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (en && (req != 2'b00)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/io_arbiter.sv
// Two-requester round-robin sequencer driving the IO block strobes; reads return
// in_data captured RD_LAT cycles after the IO sampling edge.
module io_arbiter
  import io_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [PORT_W-1:0] port0,
  input  logic [PORT_W-1:0] port1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [1:0]        grant,
  output logic              io_enable,
  output logic              sel_io,
  output logic [PORT_W-1:0] sel_p,
  output logic [DATA_W-1:0] out_data,
  input  logic [DATA_W-1:0] in_data
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("io_arbiter: RD_LAT=%0d outside legal range 1..15", RD_LAT);
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LAT - 1);

  io_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       gnt;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req   ({req1, req0}),
    .en    (state == S_IDLE),
    .gnt   (gnt)
  );

  assign busy = (state != S_IDLE);

  // sel_io/sel_p/out_data double as the latched transaction registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      grant     <= 2'b00;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      io_enable <= 1'b0;
      sel_io    <= IO_READ;
      sel_p     <= '0;
      out_data  <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt != 2'b00) begin
            grant     <= gnt;
            sel_io    <= gnt[0] ? rw0    : rw1;
            sel_p     <= gnt[0] ? port0  : port1;
            out_data  <= gnt[0] ? wdata0 : wdata1;
            io_enable <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          io_enable <= 1'b0;
          if (sel_io == IO_WRITE) begin
            {ack1, ack0} <= grant;
            state        <= S_DONE;
          end else begin
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == LAST_CNT) begin
            rdata        <= in_data;
            {ack1, ack0} <= grant;
            state        <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          grant <= 2'b00;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
